// File: rtl/fetch_queue.sv
// Instruction-fetch unit: issues in-order fetch requests and buffers the returned
// instructions with their PCs in a small circular queue that decode drains.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            sclk_i,
  input  logic            srst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [31:0]     imem_resp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_inst_o,
  output logic [XLEN-1:0] out_pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  pc_d   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d, unfilled_q, unfilled_d, drop_q, drop_d;

  logic          req_fire, out_fire, resp_drop, resp_fill;
  logic [CW:0]   in_use;
  logic [CW:0]   drop_sum;

  // Occupied entries plus responses still to be discarded bound the outstanding requests.
  assign in_use           = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid_o = in_use < (CW+1)'(DEPTH);
  assign imem_req_addr_o  = fetch_pc_q;
  assign out_valid_o      = filled_q[head_q];
  assign out_inst_o       = inst_q[head_q];
  assign out_pc_o         = pc_q[head_q];

  assign req_fire  = imem_req_valid_o && imem_req_ready_i;
  assign out_fire  = out_valid_o && out_ready_i;
  assign resp_drop = imem_resp_valid_i && (drop_q != '0);
  assign resp_fill = imem_resp_valid_i && (drop_q == '0) && (unfilled_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    filled_d   = filled_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    drop_d     = drop_q;
    drop_sum   = {1'b0, drop_q} + {1'b0, unfilled_q} + (CW+1)'(req_fire)
                 - (CW+1)'(resp_drop || resp_fill);

    if (redirect_i) begin
      // Everything still in flight, including a request accepted this cycle, becomes a drop.
      fetch_pc_d = redirect_target_i & ~XLEN'(3);
      filled_d   = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      drop_d     = drop_sum[CW-1:0];
    end else begin
      if (req_fire) begin
        pc_d[tail_q]     = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
        fetch_pc_d       = fetch_pc_q + XLEN'(4);
      end
      if (resp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_fill) begin
        inst_d[fill_q]   = imem_resp_data_i;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      // Clearing filled on pop keeps a stale flag from showing once the queue wraps empty.
      if (out_fire) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      count_d    = count_q + CW'(req_fire) - CW'(out_fire);
      unfilled_d = unfilled_q + CW'(req_fire) - CW'(resp_fill);
    end
  end

  always_ff @(posedge sclk_i) begin
    if (srst_i) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= '{default: '0};
      inst_q     <= '{default: '0};
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      filled_q   <= filled_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      drop_q     <= drop_d;
    end
  end

endmodule
